shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_pkg.sv | 12 +
 rtl/shift_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the serial-chain shift sequencer.
// Holds the controller state encoding, which is used by the RTL and is visible to anything that probes it.
// No ports; types only.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Serializes one WIDTH-bit word into a fixed-latency serial chain and reassembles the returned bits.
// Ports: req_valid/req_ready/req_data accept a word; si/so/shift_en drive the chain; rsp_valid/rsp_ready/rsp_data
//        return the captured word; busy is high outside IDLE. clk rising edge, rst synchronous active-high.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LAT       = 5,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   output logic             si,
   input  logic             so,
   output logic             shift_en,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + LAT + 1);
   localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAT  = CW'(LAT);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + LAT - 1);

   // Word and capture registers are kept in shift order (bit 0 = first bit on
   // the wire), so the datapath is independent of MSB_FIRST; only the
   // load and unload paths reorder.
   function automatic logic [WIDTH-1:0] to_order(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
      end
      return r;
   endfunction

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [WIDTH-1:0] word_sh;
   logic [CW-1:0]    cap_idx;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      cap_d      = cap_q;
      rsp_data_d = rsp_data_q;
      req_ready  = 1'b0;
      shift_en   = 1'b0;
      si         = 1'b0;
      rsp_valid  = 1'b0;
      word_sh    = word_q >> cnt_q;
      // Bit returning from the chain this cycle was launched LAT cycles ago.
      cap_idx    = cnt_q - CNT_LAT;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               word_d  = to_order(req_data);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            // Past the last data bit the chain is flushed with zeros.
            if (cnt_q < CNT_W) begin
               si = word_sh[0];
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q >= CNT_LAT) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (cap_idx == CW'(i)) begin
                     cap_d[i] = so;
                  end
               end
            end
            // The final bit lands in cap_d on the same edge that publishes the
            // response, so the response is taken from cap_d rather than cap_q.
            if (cnt_q == CNT_LAST) begin
               state_d    = DONE;
               rsp_data_d = to_order(cap_d);
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         word_q     <= '0;
         cap_q      <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         cap_q      <= cap_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign rsp_data = rsp_data_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

   localparam int W = 8;
   localparam int L = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic [W-1:0] req_data;
   logic         rsp_ready;
   logic [1:0]   req_ready, si, shift_en, rsp_valid, busy, so;
   logic [W-1:0] rsp_data0, rsp_data1;
   logic [L-1:0] ch0 = '0, ch1 = '0;

   int n_chk = 0, n_err = 0, n_start = 0;
   int m_acc = 0, d_acc = 0;

   // Transaction-level reference: idle, or "m_t cycles since accept".
   bit           m_active = 1'b0;
   int           m_t = 0;
   logic [W-1:0] m_word = '0, m_rsp = '0;
   logic [12:0]  last_r0, last_r1;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(W), .LAT(L), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]), .req_data(req_data),
      .si(si[0]), .so(so[0]), .shift_en(shift_en[0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .busy(busy[0]));

   shift_seq_ctrl #(.WIDTH(W), .LAT(L), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]), .req_data(req_data),
      .si(si[1]), .so(so[1]), .shift_en(shift_en[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .busy(busy[1]));

   // Attached chain: four shift stages plus a registered output = L flops.
   always @(posedge clk) begin
      ch0 <= {ch0[L-2:0], si[0]};
      ch1 <= {ch1[L-2:0], si[1]};
   end
   assign so = {ch1[L-1], ch0[L-1]};

   always @(posedge clk) begin
      if (!rst && req_valid && req_ready[0]) d_acc <= d_acc + 1;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_active <= 1'b0;
         m_t      <= 0;
         m_word   <= '0;
         m_rsp    <= '0;
      end else if (!m_active) begin
         if (req_valid) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_word   <= req_data;
            m_acc    <= m_acc + 1;
         end
      end else if (m_t < W + L) begin
         m_t <= m_t + 1;
         if (m_t == W + L - 1) m_rsp <= m_word;
      end else if (rsp_ready) begin
         m_active <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the reference.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            bit           e_shift, e_done, e_si;
            logic [W-1:0] act_dat;
            e_shift = m_active && (m_t < W + L);
            e_done  = m_active && (m_t >= W + L);
            e_si    = 1'b0;
            if (e_shift && m_t < W) e_si = m_word[(i == 1) ? (W - 1 - m_t) : m_t];
            act_dat = (i == 1) ? rsp_data1 : rsp_data0;
            chk($sformatf("req_ready%0d", i), 32'(req_ready[i]), 32'(!m_active));
            chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_active));
            chk($sformatf("shift_en%0d", i), 32'(shift_en[i]), 32'(e_shift));
            chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(e_done));
            chk($sformatf("rsp_data%0d", i), 32'(act_dat), 32'(m_rsp));
            if (!e_done) chk($sformatf("si%0d", i), 32'(si[i]), 32'(e_si));
         end
      end
   end

   // Called #1 after an edge with the controllers idle.
   task automatic start(input logic [W-1:0] w);
      chk("accept_ready", 32'(req_ready[0]), 32'd1);
      req_valid = 1'b1;
      req_data  = w;
      n_start++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_data  = W'($urandom);
   endtask

   task automatic finish(input logic [W-1:0] w, input int hold, input bit tog);
      int lat = 0;
      logic [12:0] r0 = '0, r1 = '0;
      while (rsp_valid[0] !== 1'b1 && lat < 200) begin
         if (shift_en[0] === 1'b1) r0 = {r0[11:0], si[0]};
         if (shift_en[1] === 1'b1) r1 = {r1[11:0], si[1]};
         if (tog) begin
            req_valid = 1'($urandom);
            req_data  = W'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 1'b0;
      chk("rsp_latency", 32'(lat), 32'd13);
      chk("rsp_word_lsb", 32'(rsp_data0), 32'(w));
      chk("rsp_word_msb", 32'(rsp_data1), 32'(w));
      last_r0 = r0;
      last_r1 = r1;
      repeat (hold) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] w;
      rst = 1'b1; req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_ready", 32'(req_ready), 32'h3);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_shift_en", 32'(shift_en), 32'h0);
      chk("reset_rsp_data", 32'({rsp_data1, rsp_data0}), 32'h0);

      start(8'hA5); finish(8'hA5, 0, 1'b0);
      chk("si_seq_A5_lsb", 32'(last_r0), 32'(13'b1010010100000));

      start(8'h3C); finish(8'h3C, 10, 1'b0);
      chk("si_seq_3C_msb", 32'(last_r1), 32'(13'b0011110000000));

      // Back-to-back: accepted on the edge right after the response handshake.
      start(8'h5A); finish(8'h5A, 0, 1'b1);

      // Abort mid-transfer at cnt=4.
      start(8'hFF);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ready", 32'(req_ready), 32'h3);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("abort_shift_en", 32'(shift_en), 32'h0);
      chk("abort_si", 32'(si), 32'h0);
      chk("abort_rsp_data", 32'({rsp_data1, rsp_data0}), 32'h0);
      start(8'h81); finish(8'h81, 0, 1'b0);

      start(8'h00); finish(8'h00, 0, 1'b0);
      start(8'hFF); finish(8'hFF, 0, 1'b0);

      for (int k = 0; k < 20; k++) begin
         w = W'($urandom);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         start(w);
         finish(w, $urandom_range(0, 3), 1'($urandom));
      end

      repeat (2) begin @(posedge clk); #1; end
      chk("accept_count_dut", 32'(d_acc), 32'(m_acc));
      chk("accept_count_model", 32'(m_acc), 32'(n_start));
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
